// File: rtl/multi_key_press_detector.sv
// Multi-key debounced press detector: short / long / double per key.
// Ports: clk, reset (sync, active-high), key_in raw levels; key_level
// debounced levels; short/long/double_press per-key 1-cycle pulses;
// event_valid/event_key/event_type registered lowest-index summary.
module multi_key_press_detector #(
  parameter int NUM_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES   = 200000,
  parameter int LONG_CYCLES       = 100000000,
  parameter int DOUBLE_GAP_CYCLES = 30000000,
  parameter int DOUBLE_EN         = 1,
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] short_press,
  output logic [NUM_KEYS-1:0] long_press,
  output logic [NUM_KEYS-1:0] double_press,
  output logic                event_valid,
  output logic [KW-1:0]       event_key,
  output logic [1:0]          event_type
);

  localparam int MAX_LG = (LONG_CYCLES > DOUBLE_GAP_CYCLES) ?
                          LONG_CYCLES : DOUBLE_GAP_CYCLES;
  localparam int MAXT   = (MAX_LG > DEBOUNCE_CYCLES) ?
                          MAX_LG : DEBOUNCE_CYCLES;
  localparam int CW     = $clog2(MAXT + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_HOLD
  } state_t;

  logic [NUM_KEYS-1:0] w_short;
  logic [NUM_KEYS-1:0] w_long;
  logic [NUM_KEYS-1:0] w_dbl;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic          r_s1;
    logic          r_s2;
    logic          r_armed;
    logic          r_level;
    logic [CW-1:0] r_arm_cnt;
    logic [CW-1:0] r_db_cnt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_short;
    logic          r_long;
    logic          r_dbl;
    logic          w_s;
    logic          w_l;
    logic          w_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1      <= 1'b0;
        r_s2      <= 1'b0;
        r_armed   <= 1'b0;
        r_level   <= 1'b0;
        r_arm_cnt <= '0;
        r_db_cnt  <= '0;
      end else begin
        r_s1 <= key_in[g];
        r_s2 <= r_s1;
        // Arm only after a full debounce window of released input,
        // so a key held through reset never reports.
        if (!r_armed) begin
          if (!r_s2) begin
            if (r_arm_cnt == DB_LAST) begin
              r_armed   <= 1'b1;
              r_arm_cnt <= '0;
            end else begin
              r_arm_cnt <= r_arm_cnt + 1'b1;
            end
          end else begin
            r_arm_cnt <= '0;
          end
        end
        if (r_s2 != r_level) begin
          if (r_db_cnt == DB_LAST) begin
            if (r_armed) begin
              r_level  <= r_s2;
              r_db_cnt <= '0;
            end
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end else begin
          r_db_cnt <= '0;
        end
      end
    end

    // r_cnt is the hold counter in PRESS1 and the gap counter in GAP.
    // It is loaded with 1 on entry so that the cycle of entry counts.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_s         = 1'b0;
      w_l         = 1'b0;
      w_d         = 1'b0;
      if (r_armed) begin
        unique case (r_state)
          S_IDLE: begin
            if (r_level) begin
              w_state_nxt = S_PRESS1;
              w_cnt_nxt   = CNT_ONE;
            end
          end
          S_PRESS1: begin
            if (r_level) begin
              if (r_cnt >= LONG_LAST) begin
                w_l         = 1'b1;
                w_state_nxt = S_HOLD;
              end else begin
                w_cnt_nxt = r_cnt + 1'b1;
              end
            end else if (DOUBLE_EN != 0) begin
              w_state_nxt = S_GAP;
              w_cnt_nxt   = CNT_ONE;
            end else begin
              w_s         = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
          S_GAP: begin
            // A rise beats gap expiry in the same cycle.
            if (r_level) begin
              w_d         = 1'b1;
              w_state_nxt = S_HOLD;
            end else if (r_cnt >= GAP_LAST) begin
              w_s         = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
          S_HOLD: begin
            if (!r_level) begin
              w_state_nxt = S_IDLE;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_short <= 1'b0;
        r_long  <= 1'b0;
        r_dbl   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_short <= w_s;
        r_long  <= w_l;
        r_dbl   <= w_d;
      end
    end

    assign w_short[g]      = w_s;
    assign w_long[g]       = w_l;
    assign w_dbl[g]        = w_d;
    assign key_level[g]    = r_level;
    assign short_press[g]  = r_short;
    assign long_press[g]   = r_long;
    assign double_press[g] = r_dbl;
  end

  logic          w_ev_valid;
  logic [KW-1:0] w_ev_key;
  logic [1:0]    w_ev_type;
  logic          r_ev_valid;
  logic [KW-1:0] r_ev_key;
  logic [1:0]    r_ev_type;

  // Scan from the top so the lowest-index key is written last and wins.
  always_comb begin
    w_ev_valid = 1'b0;
    w_ev_key   = '0;
    w_ev_type  = 2'b00;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (w_short[k] | w_long[k] | w_dbl[k]) begin
        w_ev_valid = 1'b1;
        w_ev_key   = KW'(k);
        if (w_dbl[k]) begin
          w_ev_type = 2'b11;
        end else if (w_long[k]) begin
          w_ev_type = 2'b10;
        end else begin
          w_ev_type = 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ev_valid <= 1'b0;
      r_ev_key   <= '0;
      r_ev_type  <= 2'b00;
    end else begin
      r_ev_valid <= w_ev_valid;
      r_ev_key   <= w_ev_key;
      r_ev_type  <= w_ev_type;
    end
  end

  assign event_valid = r_ev_valid;
  assign event_key   = r_ev_key;
  assign event_type  = r_ev_type;

endmodule

// File: tb/tb_multi_key_press_detector.sv
// Bench for multi_key_press_detector: directed plan plus random presses
// checked every cycle against a timestamp-scheduling reference model.
module tb_multi_key_press_detector;

  localparam int NK   = 2;
  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int GAP  = 10;
  localparam int DEN  = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] key_level;
  logic [NK-1:0] short_press;
  logic [NK-1:0] long_press;
  logic [NK-1:0] double_press;
  logic          event_valid;
  logic [0:0]    event_key;
  logic [1:0]    event_type;

  multi_key_press_detector #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LONG),
    .DOUBLE_GAP_CYCLES(GAP),
    .DOUBLE_EN(DEN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_in(key_in),
    .key_level(key_level),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press),
    .event_valid(event_valid),
    .event_key(event_key),
    .event_type(event_type)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: sync delay line, run-length debounce and arming,
  // then press classification by scheduling pulse times on level edges.
  int            n = 0;
  logic [NK-1:0] m_lvl, m_d1, m_d2, m_arm;
  int            dcnt[NK], lowcnt[NK];
  int            sdue[NK], ldue[NK], ddue[NK];
  logic [NK-1:0] e_s, e_l, e_d;
  logic          e_v;
  int            e_k;
  logic [1:0]    e_t;

  int obs_s[NK], obs_l[NK], obs_d[NK], obs_lvl[NK], obs_both;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)",
             tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0; m_d1 = '0; m_d2 = '0; m_arm = '0;
    e_s = '0; e_l = '0; e_d = '0;
    e_v = 1'b0; e_k = 0; e_t = 2'b00;
    for (int i = 0; i < NK; i++) begin
      dcnt[i] = 0; lowcnt[i] = 0;
      sdue[i] = -1; ldue[i] = -1; ddue[i] = -1;
    end
  endtask

  task automatic model_step(input logic [NK-1:0] k);
    logic u, was;
    n++;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NK; i++) begin
      e_s[i] = (sdue[i] == n);
      e_l[i] = (ldue[i] == n);
      e_d[i] = (ddue[i] == n);
    end
    for (int i = 0; i < NK; i++) begin
      u = m_d2[i];
      m_d2[i] = m_d1[i];
      m_d1[i] = k[i];
      was = m_arm[i];
      if (!m_arm[i]) begin
        if (!u) begin
          lowcnt[i]++;
          if (lowcnt[i] >= DB) m_arm[i] = 1'b1;
        end else begin
          lowcnt[i] = 0;
        end
      end
      if (u != m_lvl[i]) begin
        dcnt[i]++;
        if (dcnt[i] >= DB && was) begin
          m_lvl[i] = u;
          dcnt[i] = 0;
          if (u) begin
            // second press inside the gap window -> double next cycle
            if (DEN != 0 && sdue[i] > n) begin
              ddue[i] = n + 1;
              sdue[i] = -1;
            end else begin
              ldue[i] = n + LONG;
            end
          end else if (ldue[i] > n) begin
            ldue[i] = -1;
            sdue[i] = n + ((DEN != 0) ? GAP : 1);
          end
        end
      end else begin
        dcnt[i] = 0;
      end
    end
    e_v = 1'b0; e_k = 0; e_t = 2'b00;
    for (int i = 0; i < NK; i++) begin
      if (!e_v && (e_s[i] || e_l[i] || e_d[i])) begin
        e_v = 1'b1;
        e_k = i;
        e_t = e_d[i] ? 2'b11 : (e_l[i] ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic tick(input logic [NK-1:0] k);
    key_in = k;
    @(posedge clk);
    model_step(k);
    #1;
    chk("key_level", int'(key_level), int'(m_lvl));
    chk("short_press", int'(short_press), int'(e_s));
    chk("long_press", int'(long_press), int'(e_l));
    chk("double_press", int'(double_press), int'(e_d));
    chk("event_valid", int'(event_valid), int'(e_v));
    chk("event_key", int'(event_key), e_k);
    chk("event_type", int'(event_type), int'(e_t));
    for (int i = 0; i < NK; i++) begin
      obs_s[i] += int'(short_press[i]);
      obs_l[i] += int'(long_press[i]);
      obs_d[i] += int'(double_press[i]);
      obs_lvl[i] += int'(key_level[i]);
    end
    if (short_press == 2'b11 && event_valid && event_key == 1'b0 &&
        event_type == 2'b01)
      obs_both++;
  endtask

  task automatic ticks(input logic [NK-1:0] k, input int c);
    for (int j = 0; j < c; j++) tick(k);
  endtask

  task automatic clr_obs();
    obs_both = 0;
    for (int i = 0; i < NK; i++) begin
      obs_s[i] = 0; obs_l[i] = 0; obs_d[i] = 0; obs_lvl[i] = 0;
    end
  endtask

  initial begin
    logic [NK-1:0] rk;
    model_reset();
    clr_obs();
    reset = 1'b1;
    ticks(2'b00, 3);
    chk("reset_event_valid", int'(event_valid), 0);
    reset = 1'b0;
    ticks(2'b00, 10);

    // short press on key 0
    clr_obs();
    ticks(2'b01, 8);
    ticks(2'b00, 30);
    chk("s1_short0_count", obs_s[0], 1);
    chk("s1_lvl0_cycles", obs_lvl[0], 8);

    // long press on key 1, nothing on release
    clr_obs();
    ticks(2'b10, 40);
    ticks(2'b00, 30);
    chk("s2_long1_count", obs_l[1], 1);
    chk("s2_short1_count", obs_s[1], 0);

    // double press on key 0
    clr_obs();
    ticks(2'b01, 8);
    ticks(2'b00, 6);
    ticks(2'b01, 8);
    ticks(2'b00, 30);
    chk("s3_double0_count", obs_d[0], 1);
    chk("s3_short0_count", obs_s[0], 0);

    // chatter shorter than the debounce window
    clr_obs();
    for (int i = 0; i < 30; i++) tick(((i / 2) % 2 == 0) ? 2'b01 : 2'b00);
    ticks(2'b00, 20);
    chk("s4_lvl0_cycles", obs_lvl[0], 0);
    chk("s4_pulses0", obs_s[0] + obs_l[0] + obs_d[0], 0);

    // simultaneous short presses
    clr_obs();
    ticks(2'b11, 8);
    ticks(2'b00, 30);
    chk("s5_both_short_evt0", obs_both, 1);
    chk("s5_short1_count", obs_s[1], 1);

    // key held through reset stays silent until released
    clr_obs();
    reset = 1'b1;
    ticks(2'b01, 3);
    reset = 1'b0;
    ticks(2'b01, 40);
    ticks(2'b00, 10);
    chk("s6_held_pulses", obs_s[0] + obs_l[0] + obs_d[0], 0);
    ticks(2'b01, 8);
    ticks(2'b00, 30);
    chk("s6_short0_count", obs_s[0], 1);

    // random press patterns, one reset mid-run
    for (int r = 0; r < 60; r++) begin
      rk = NK'($urandom_range(0, 3));
      if (r == 30) begin
        reset = 1'b1;
        ticks(rk, 2);
        reset = 1'b0;
      end
      ticks(rk, $urandom_range(1, 26));
    end
    ticks(2'b00, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
